// File: rtl/lnk_walker_if.sv
// Control, status and node-memory signals of the linked-list walker.
// master = requester/memory side, slave = walker.
interface lnk_walker_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned HOP_W  = 8
);
    logic              start;
    logic              abort;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] key;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_a;
    logic [ADDR_W-1:0] mem_data_b;
    logic              busy;
    logic              done;
    logic              found;
    logic [ADDR_W-1:0] result_addr;
    logic [HOP_W-1:0]  hop_count;
    logic              timeout;

    modport master (
        output start, abort, mode, head_addr, key, mem_data_a, mem_data_b,
        input  mem_addr, busy, done, found, result_addr, hop_count, timeout
    );

    modport slave (
        input  start, abort, mode, head_addr, key, mem_data_a, mem_data_b,
        output mem_addr, busy, done, found, result_addr, hop_count, timeout
    );
endinterface

// File: rtl/lnk_walker.sv
// Linked-list walker: follows next pointers from a head node until a match or a null pointer.
// Optional hop limit enabled by defining LNK_HOP_LIMIT_EN.
module lnk_walker #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned HOP_W    = 8,
    parameter int unsigned MAX_HOPS = 255
) (
    input logic          clk,
    input logic          rst_n,
    lnk_walker_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StFetch, StCheck, StDone} state_e;

    if (MAX_HOPS < 1 || MAX_HOPS > (2 ** HOP_W) - 1) begin : g_bad_max_hops
        $error("lnk_walker: MAX_HOPS out of range for HOP_W");
    end

    state_e            state_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] key_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              found_q;
    logic [ADDR_W-1:0] result_q;
    logic [HOP_W-1:0]  hop_q;
    logic              match;
    logic              next_null;

    assign next_null = (bus.mem_data_b == '0);

    always_comb begin
        match = 1'b0;
        case (mode_q)
            2'd1:    match = (hop_q == key_q[HOP_W-1:0]);
            2'd2:    match = next_null;
            default: match = (bus.mem_data_a == key_q);
        endcase
    end

`ifdef LNK_HOP_LIMIT_EN
    logic timeout_q;
    logic hop_limit;

    assign hop_limit   = (hop_q == HOP_W'(MAX_HOPS));
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    // mem_addr_q doubles as the current node address; it only moves when entering StFetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mode_q     <= 2'd0;
            key_q      <= '0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
            result_q   <= '0;
            hop_q      <= '0;
`ifdef LNK_HOP_LIMIT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        found_q  <= 1'b0;
                        result_q <= '0;
                        hop_q    <= '0;
`ifdef LNK_HOP_LIMIT_EN
                        timeout_q <= 1'b0;
`endif
                        if (bus.head_addr != '0) begin
                            mode_q     <= bus.mode;
                            key_q      <= bus.key;
                            mem_addr_q <= bus.head_addr;
                            busy_q     <= 1'b1;
                            state_q    <= StFetch;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StFetch: begin
                    if (bus.abort) begin
                        busy_q   <= 1'b0;
                        found_q  <= 1'b0;
                        result_q <= '0;
                        state_q  <= StIdle;
                    end else begin
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (bus.abort) begin
                        busy_q   <= 1'b0;
                        found_q  <= 1'b0;
                        result_q <= '0;
                        state_q  <= StIdle;
                    end else if (match) begin
                        found_q  <= 1'b1;
                        result_q <= mem_addr_q;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end else if (next_null) begin
                        found_q  <= 1'b0;
                        result_q <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
`ifdef LNK_HOP_LIMIT_EN
                    else if (hop_limit) begin
                        found_q   <= 1'b0;
                        result_q  <= '0;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= StDone;
                    end
`endif
                    else begin
                        mem_addr_q <= bus.mem_data_b;
                        if (hop_q != '1) begin
                            hop_q <= hop_q + HOP_W'(1);
                        end
                        state_q <= StFetch;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.found       = found_q;
    assign bus.result_addr = result_q;
    assign bus.hop_count   = hop_q;

endmodule

// File: tb/tb_lnk_walker.sv
// Self-checking bench for lnk_walker: directed list walks plus randomized lists against a
// list-walking reference model.
module tb_lnk_walker;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned HOP_W    = 8;
    localparam int unsigned MAX_HOPS = 4;
    localparam int unsigned MEM_N    = 1 << ADDR_W;
    localparam int          HOP_MAX  = (1 << HOP_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lnk_walker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HOP_W(HOP_W)) bus ();

    lnk_walker #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .HOP_W    (HOP_W),
        .MAX_HOPS (MAX_HOPS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DATA_W-1:0] mem_a [MEM_N];
    logic [ADDR_W-1:0] mem_b [MEM_N];

    // Node memory: registered read, data one cycle after the address.
    always @(posedge clk) begin
        bus.mem_data_a <= mem_a[bus.mem_addr];
        bus.mem_data_b <= mem_b[bus.mem_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic              found;
        logic [ADDR_W-1:0] res;
        logic [HOP_W-1:0]  hops;
        logic              tmo;
        int                lat;
    } exp_t;

    // Walk the memory array the way the list is defined, counting pointers followed.
    function automatic exp_t model_walk(input logic [1:0] m, input logic [ADDR_W-1:0] head,
                                        input logic [DATA_W-1:0] k);
        exp_t e;
        int steps;
        int sat;
        logic [ADDR_W-1:0] a;
        logic hit;
        e.found = 1'b0;
        e.res   = '0;
        e.hops  = '0;
        e.tmo   = 1'b0;
        e.lat   = 1;
        if (head == '0) return e;
        a = head;
        steps = 0;
        sat = 0;
        for (int it = 0; it < 10000; it++) begin
            sat = (steps > HOP_MAX) ? HOP_MAX : steps;
            case (m)
                2'd1:    hit = (sat == int'(k[HOP_W-1:0]));
                2'd2:    hit = (mem_b[a] == '0);
                default: hit = (mem_a[a] == k);
            endcase
            if (hit) begin
                e.found = 1'b1;
                e.res   = a;
                break;
            end
            if (mem_b[a] == '0) break;
`ifdef LNK_HOP_LIMIT_EN
            if (sat == int'(MAX_HOPS)) begin
                e.tmo = 1'b1;
                break;
            end
`endif
            a = mem_b[a];
            steps++;
        end
        sat    = (steps > HOP_MAX) ? HOP_MAX : steps;
        e.hops = HOP_W'(sat);
        e.lat  = 2 * (steps + 1) + 1;
        return e;
    endfunction

    task automatic set_node(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [ADDR_W-1:0] nxt);
        mem_a[a] = d;
        mem_b[a] = nxt;
    endtask

    task automatic init_fixed();
        set_node(12'h010, 16'h0005, 12'h020);
        set_node(12'h020, 16'h0007, 12'h030);
        set_node(12'h030, 16'h0009, 12'h000);
    endtask

    task automatic run_walk(input string tag, input logic [1:0] m, input logic [ADDR_W-1:0] head,
                            input logic [DATA_W-1:0] k, input bit with_abort, input bit poke);
        exp_t e;
        int cyc;
        bit got;
        e = model_walk(m, head, k);
        @(negedge clk);
        bus.mode = m;
        bus.head_addr = head;
        bus.key = k;
        bus.start = 1'b1;
        bus.abort = with_abort;
        cyc = 0;
        got = 1'b0;
        while (cyc < e.lat + 8) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (cyc == 1) check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
            if (poke && cyc == 2) begin
                bus.start = 1'b1;
                bus.mode = 2'($urandom_range(0, 3));
                bus.head_addr = ADDR_W'($urandom_range(1, MEM_N - 1));
            end
        end
        bus.start = 1'b0;
        check_eq({tag, "_done_seen"}, 32'(got), 32'd1);
        check_eq({tag, "_latency"}, 32'(cyc), 32'(e.lat));
        check_eq({tag, "_found"}, 32'(bus.found), 32'(e.found));
        check_eq({tag, "_result"}, 32'(bus.result_addr), 32'(e.res));
        check_eq({tag, "_hops"}, 32'(bus.hop_count), 32'(e.hops));
        check_eq({tag, "_timeout"}, 32'(bus.timeout), 32'(e.tmo));
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    // Abort raised during cycle c after the start cycle (1 <= c < latency).
    task automatic run_abort(input string tag, input logic [1:0] m, input logic [ADDR_W-1:0] head,
                             input logic [DATA_W-1:0] k, input int c);
        exp_t e;
        int done_n;
        e = model_walk(m, head, k);
        @(negedge clk);
        bus.mode = m;
        bus.head_addr = head;
        bus.key = k;
        bus.start = 1'b1;
        done_n = 0;
        for (int cyc = 1; cyc <= e.lat + 6; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = (cyc == c);
            if (bus.done) done_n++;
        end
        bus.abort = 1'b0;
        check_eq({tag, "_no_done"}, 32'(done_n), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_found"}, 32'(bus.found), 32'd0);
        check_eq({tag, "_result"}, 32'(bus.result_addr), 32'd0);
    endtask

    logic [ADDR_W-1:0] lst[$];

    task automatic build_list(input int len);
        logic [ADDR_W-1:0] a;
        bit dup;
        lst.delete();
        while (lst.size() < len) begin
            a = ADDR_W'($urandom_range(1, MEM_N - 1));
            dup = 1'b0;
            foreach (lst[i]) if (lst[i] == a) dup = 1'b1;
            if (!dup) lst.push_back(a);
        end
        for (int i = 0; i < len; i++) begin
            set_node(lst[i], DATA_W'($urandom_range(0, 7)), (i == len - 1) ? '0 : lst[i + 1]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] m;
        logic [ADDR_W-1:0] head;
        logic [DATA_W-1:0] k;
        int len;
        int c;
        exp_t e;
        int done_n;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.mode = 2'd0;
        bus.head_addr = '0;
        bus.key = '0;
        for (int i = 0; i < int'(MEM_N); i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_found", 32'(bus.found), 32'd0);
        check_eq("rst_result", 32'(bus.result_addr), 32'd0);
        check_eq("rst_hops", 32'(bus.hop_count), 32'd0);
        check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("rst_timeout", 32'(bus.timeout), 32'd0);
        rst_n = 1'b1;

        init_fixed();
        run_walk("find_mid", 2'd0, 12'h010, 16'h0007, 1'b0, 1'b0);
        check_eq("find_mid_res_const", 32'(bus.result_addr), 32'h020);
        check_eq("find_mid_hops_const", 32'(bus.hop_count), 32'd1);
        // Abort while idle must leave the held results alone.
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("hold_found", 32'(bus.found), 32'd1);
        check_eq("hold_result", 32'(bus.result_addr), 32'h020);
        check_eq("hold_hops", 32'(bus.hop_count), 32'd1);

        run_walk("miss", 2'd0, 12'h010, 16'h00FF, 1'b0, 1'b0);
        check_eq("miss_found_const", 32'(bus.found), 32'd0);
        run_walk("nth2", 2'd1, 12'h010, 16'h0002, 1'b0, 1'b0);
        check_eq("nth2_res_const", 32'(bus.result_addr), 32'h030);
        run_walk("tail", 2'd2, 12'h010, 16'h1234, 1'b0, 1'b0);
        check_eq("tail_res_const", 32'(bus.result_addr), 32'h030);
        run_walk("empty", 2'd0, 12'h000, 16'h0005, 1'b0, 1'b0);
        run_walk("mode3", 2'd3, 12'h010, 16'h0005, 1'b1, 1'b1);
        run_abort("abort_c3", 2'd0, 12'h010, 16'h0009, 3);
        run_walk("after_abort", 2'd0, 12'h010, 16'h0009, 1'b0, 1'b0);
        check_eq("after_abort_res_const", 32'(bus.result_addr), 32'h030);

`ifdef LNK_HOP_LIMIT_EN
        mem_b[12'h030] = 12'h010;
        run_walk("hop_limit", 2'd0, 12'h010, 16'hFFFF, 1'b0, 1'b0);
        check_eq("hop_limit_tmo_const", 32'(bus.timeout), 32'd1);
        check_eq("hop_limit_hops_const", 32'(bus.hop_count), 32'd4);
        init_fixed();
`endif

        // Long list: hop counter must saturate rather than wrap.
        for (int i = 0; i < 300; i++) begin
            set_node(ADDR_W'(12'h100 + i), DATA_W'(i), (i == 299) ? '0 : ADDR_W'(12'h101 + i));
        end
        run_walk("saturate", 2'd2, 12'h100, 16'h0000, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            len = $urandom_range(1, 8);
            build_list(len);
            m = 2'($urandom_range(0, 3));
            head = ($urandom_range(0, 9) == 0) ? '0 : lst[$urandom_range(0, len - 1)];
            if (m == 2'd1) k = DATA_W'($urandom_range(0, len + 1));
            else if ($urandom_range(0, 1) == 1) k = mem_a[lst[$urandom_range(0, len - 1)]];
            else k = DATA_W'($urandom);
            if (t % 4 == 3 && head != '0) begin
                e = model_walk(m, head, k);
                c = $urandom_range(1, e.lat - 1);
                run_abort("rnd_abort", m, head, k, c);
            end else begin
                run_walk("rnd", m, head, k, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            end
        end

        // Reset in the second CHECK of a walk.
        init_fixed();
        @(negedge clk);
        bus.mode = 2'd2;
        bus.head_addr = 12'h010;
        bus.key = '0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        check_eq("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("midrst_hops", 32'(bus.hop_count), 32'd0);
        check_eq("midrst_found", 32'(bus.found), 32'd0);
        check_eq("midrst_result", 32'(bus.result_addr), 32'd0);
        done_n = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done) done_n++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) done_n++;
        end
        check_eq("midrst_no_done", 32'(done_n), 32'd0);
        run_walk("post_rst", 2'd0, 12'h010, 16'h0007, 1'b0, 1'b0);
        check_eq("post_rst_res_const", 32'(bus.result_addr), 32'h020);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
